cas_block_sequencer: RTL and testbench



---
 rtl/cas_pkg.sv | 28 ++
 rtl/cas_block_sequencer_if.sv | 34 +++
 rtl/cas_byte_emitter.sv | 58 +++++
 rtl/cas_block_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cas_block_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cas_pkg.sv
// Shared state encoding and framing constants for the
// cassette block sequencer and its byte emitter.
package cas_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEADER,
    S_SYNC0,
    S_SYNC1,
    S_TYPE,
    S_LEN,
    S_FETCH,
    S_DATA,
    S_CSUM,
    S_TRAIL,
    S_GAP,
    S_DRAIN
  } cas_state_e;

  localparam logic [7:0] CAS_LEADER_BYTE = 8'h55;
  localparam logic [7:0] CAS_SYNC_BYTE   = 8'h3C;

  function automatic logic is_frame(input cas_state_e s);
    return s inside {S_LEADER, S_SYNC0, S_SYNC1, S_TYPE,
                     S_LEN, S_CSUM, S_TRAIL};
  endfunction

endpackage

// File: rtl/cas_block_sequencer_if.sv
// Command, buffer-read, generator and status bundle of
// the cassette block sequencer.
interface cas_block_sequencer_if;

  logic       cmd_start;
  logic       cmd_abort;
  logic [7:0] cmd_type;
  logic [7:0] cmd_len;
  logic [7:0] cmd_leader;
  logic [7:0] data_addr;
  logic       data_rd;
  logic [7:0] data_in;
  logic       gen_start;
  logic [7:0] gen_din;
  logic       gen_done;
  logic       busy;
  logic       blk_done;
  logic       aborted;

  modport master (
    input  cmd_start, cmd_abort, cmd_type,
    input  cmd_len, cmd_leader, data_in, gen_done,
    output data_addr, data_rd, gen_start, gen_din,
    output busy, blk_done, aborted
  );

  modport slave (
    output cmd_start, cmd_abort, cmd_type,
    output cmd_len, cmd_leader, data_in, gen_done,
    input  data_addr, data_rd, gen_start, gen_din,
    input  busy, blk_done, aborted
  );

endinterface

// File: rtl/cas_byte_emitter.sv
// One-byte start/complete handshake towards square_gen:
// pulse start, arm on done low, complete on done high.
module cas_byte_emitter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [7:0] req_byte,
  input  logic       gen_done,
  output logic       gen_start,
  output logic [7:0] gen_din,
  output logic       busy,
  output logic       done
);

  logic       start_q, start_d;
  logic [7:0] din_q, din_d;
  logic       busy_q, busy_d;
  logic       armed_q, armed_d;

  // A stale high done level from the previous byte is ignored
  assign done = busy_q && armed_q && gen_done;

  always_comb begin
    start_d = req;
    din_d   = din_q;
    busy_d  = busy_q;
    armed_d = armed_q;
    if (req) begin
      din_d   = req_byte;
      busy_d  = 1'b1;
      armed_d = 1'b0;
    end else if (done) begin
      busy_d  = 1'b0;
      armed_d = 1'b0;
    end else if (busy_q && !gen_done) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      din_q   <= 8'h00;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      start_q <= start_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign gen_start = start_q;
  assign gen_din   = din_q;
  assign busy      = busy_q;

endmodule

// File: rtl/cas_block_sequencer.sv
// CoCo cassette block framer: leader, sync, type, len,
// data, checksum, trailer and gap, fed byte by byte.
module cas_block_sequencer
  import cas_pkg::*;
#(
  parameter logic [23:0] GAP_CYCLES = 24'd1000000
) (
  input logic                   clk,
  input logic                   reset_n,
  cas_block_sequencer_if.master bus
);

  cas_state_e  state_q, state_d, nxt;
  logic [7:0]  type_q, type_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  lead_q, lead_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] gap_q, gap_d;
  logic        data_rd_q, data_rd_d;
  logic        busy_q, busy_d;
  logic        blk_done_q, blk_done_d;
  logic        aborted_q, aborted_d;
  logic        emit_req, emit_busy, emit_done;
  logic [7:0]  emit_byte;
  logic        adv, fin, kill;

  cas_byte_emitter u_emit (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (emit_req),
    .req_byte (emit_byte),
    .gen_done (bus.gen_done),
    .gen_start(bus.gen_start),
    .gen_din  (bus.gen_din),
    .busy     (emit_busy),
    .done     (emit_done)
  );

  always_comb begin
    state_d    = state_q;
    nxt        = state_q;
    type_d     = type_q;
    len_d      = len_q;
    lead_d     = lead_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    gap_d      = gap_q;
    data_rd_d  = 1'b0;
    busy_d     = busy_q;
    blk_done_d = 1'b0;
    aborted_d  = aborted_q;
    emit_req   = 1'b0;
    emit_byte  = CAS_LEADER_BYTE;
    adv        = 1'b0;
    fin        = 1'b0;
    kill       = bus.cmd_abort && (state_q != S_IDLE)
                 && (state_q != S_DRAIN);

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_start && !bus.cmd_abort) begin
          state_d   = (bus.cmd_leader != 8'd0) ? S_LEADER
                                               : S_SYNC0;
          type_d    = bus.cmd_type;
          len_d     = bus.cmd_len;
          lead_d    = bus.cmd_leader;
          idx_d     = 8'd0;
          csum_d    = bus.cmd_type + bus.cmd_len;
          busy_d    = 1'b1;
          aborted_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DATA;
      S_DATA: begin
        if (!emit_busy) begin
          emit_req = 1'b1;
          csum_d   = csum_q + bus.data_in;
        end else begin
          adv = emit_done;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_CYCLES - 24'd1) fin = 1'b1;
        else gap_d = gap_q + 24'd1;
      end
      S_DRAIN: fin = emit_done || !emit_busy;
      default: begin
        if (!emit_busy) emit_req = 1'b1;
        else adv = emit_done;
      end
    endcase

    // Next byte is launched on the completion edge itself
    if (adv) begin
      unique case (state_q)
        S_LEADER: begin
          lead_d = lead_q - 8'd1;
          nxt    = (lead_q == 8'd1) ? S_SYNC0 : S_LEADER;
        end
        S_SYNC0: nxt = S_SYNC1;
        S_SYNC1: nxt = S_TYPE;
        S_TYPE:  nxt = S_LEN;
        S_LEN:   nxt = (len_q == 8'd0) ? S_CSUM : S_FETCH;
        S_DATA: begin
          if (idx_q == len_q - 8'd1) begin
            nxt = S_CSUM;
          end else begin
            nxt   = S_FETCH;
            idx_d = idx_q + 8'd1;
          end
        end
        S_CSUM:  nxt = S_TRAIL;
        default: nxt = S_GAP;
      endcase
      state_d   = nxt;
      gap_d     = 24'd0;
      data_rd_d = (nxt == S_FETCH);
      emit_req  = is_frame(nxt);
      if (state_q == S_TRAIL && GAP_CYCLES == 24'd0)
        fin = 1'b1;
    end

    unique case (state_d)
      S_SYNC1: emit_byte = CAS_SYNC_BYTE;
      S_TYPE:  emit_byte = type_q;
      S_LEN:   emit_byte = len_q;
      S_CSUM:  emit_byte = csum_q;
      S_DATA:  emit_byte = bus.data_in;
      default: emit_byte = CAS_LEADER_BYTE;
    endcase

    // The generator cannot be stopped mid-byte
    if (kill) begin
      emit_req  = 1'b0;
      data_rd_d = 1'b0;
      if (emit_busy && !emit_done) begin
        state_d = S_DRAIN;
        fin     = 1'b0;
      end else begin
        fin = 1'b1;
      end
    end

    if (fin) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      blk_done_d = 1'b1;
      aborted_d  = kill || (state_q == S_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      type_q     <= 8'h00;
      len_q      <= 8'h00;
      lead_q     <= 8'h00;
      idx_q      <= 8'h00;
      csum_q     <= 8'h00;
      gap_q      <= 24'd0;
      data_rd_q  <= 1'b0;
      busy_q     <= 1'b0;
      blk_done_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      len_q      <= len_d;
      lead_q     <= lead_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      gap_q      <= gap_d;
      data_rd_q  <= data_rd_d;
      busy_q     <= busy_d;
      blk_done_q <= blk_done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.data_addr = idx_q;
  assign bus.data_rd   = data_rd_q;
  assign bus.busy      = busy_q;
  assign bus.blk_done  = blk_done_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_cas_block_sequencer.sv
// Bench for cas_block_sequencer: random blocks against a
// byte-list model of the CoCo framing and handshake timing.
module tb_cas_block_sequencer;

  localparam int GAP = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  cas_block_sequencer_if bus ();

  cas_block_sequencer #(
    .GAP_CYCLES(24'(GAP))
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic       gdone = 1'b1;
  int         gcnt = 0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] mem [256];
  assign bus.gen_done = gdone;
  assign bus.data_in  = rdata;

  always @(posedge clk) begin
    if (bus.gen_start) begin
      gdone <= 1'b0;
      gcnt  <= 40;
    end else if (gcnt > 0) begin
      gcnt <= gcnt - 1;
      if (gcnt == 1) gdone <= 1'b1;
    end
  end

  always @(posedge clk)
    if (bus.data_rd) rdata <= mem[bus.data_addr];

  int         cyc = 0;
  int         rise_cyc = 0;
  int         ref_cyc = 0;
  int         rd_cnt = 0;
  int         blk_cnt = 0;
  int         blk_cyc = 0;
  logic       blk_ab = 1'b0;
  logic       blk_busy = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_done = 1'b1;
  logic [7:0] got_q [$];
  int         gap_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.busy && !prev_busy) ref_cyc <= cyc;
    if (gdone && !prev_done) begin
      ref_cyc  <= cyc;
      rise_cyc <= cyc;
    end
    if (bus.gen_start) begin
      got_q.push_back(bus.gen_din);
      gap_q.push_back(cyc - ref_cyc);
    end
    if (bus.data_rd) rd_cnt <= rd_cnt + 1;
    if (bus.blk_done) begin
      blk_cnt  <= blk_cnt + 1;
      blk_cyc  <= cyc;
      blk_ab   <= bus.aborted;
      blk_busy <= bus.busy;
    end
    prev_busy <= bus.busy;
    prev_done <= gdone;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q [$];
  int         egap_q [$];

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] t,
                                input logic [7:0] len,
                                input logic [7:0] ld);
    int sum;
    exp_q.delete();
    egap_q.delete();
    for (int i = 0; i < int'(ld); i++)
      exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h3C);
    exp_q.push_back(t);
    exp_q.push_back(len);
    for (int i = 0; i < int'(ld) + 4; i++)
      egap_q.push_back(1);
    sum = int'(t) + int'(len);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(mem[i]);
      egap_q.push_back(3);
      sum += int'(mem[i]);
    end
    exp_q.push_back(8'(sum % 256));
    exp_q.push_back(8'h55);
    egap_q.push_back(1);
    egap_q.push_back(1);
  endfunction

  task automatic issue(input logic [7:0] t,
                       input logic [7:0] len,
                       input logic [7:0] ld,
                       input logic st, input logic ab);
    bus.cmd_type   = t;
    bus.cmd_len    = len;
    bus.cmd_leader = ld;
    bus.cmd_start  = st;
    bus.cmd_abort  = ab;
    @(negedge clk); #1;
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
  endtask

  task automatic wait_blk(input int base, input int budget,
                          input string nm);
    int n = 0;
    while (blk_cnt == base && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, ".blk_seen"}, int'(blk_cnt != base), 1);
  endtask

  task automatic wait_starts(input int target,
                             input int budget,
                             input string nm);
    int n = 0;
    while (got_q.size() < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, ".start_seen"},
        int'(got_q.size() >= target), 1);
  endtask

  task automatic check_block(input int gb, input int rb,
                             input int bb,
                             input logic [7:0] len,
                             input string nm);
    chk({nm, ".nbytes"}, got_q.size() - gb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (gb + i < got_q.size()) begin
        chk($sformatf("%s.byte%0d", nm, i),
            int'(got_q[gb + i]), int'(exp_q[i]));
        chk($sformatf("%s.gap%0d", nm, i),
            gap_q[gb + i], egap_q[i]);
      end
    end
    chk({nm, ".nblk"}, blk_cnt - bb, 1);
    chk({nm, ".done_lat"}, blk_cyc - rise_cyc, GAP + 1);
    chk({nm, ".aborted"}, int'(blk_ab), 0);
    chk({nm, ".busy_at_done"}, int'(blk_busy), 0);
    chk({nm, ".nrd"}, rd_cnt - rb, int'(len));
  endtask

  task automatic run_block(input logic [7:0] t,
                           input logic [7:0] len,
                           input logic [7:0] ld,
                           input string nm);
    int gb, rb, bb;
    model(t, len, ld);
    gb = got_q.size();
    rb = rd_cnt;
    bb = blk_cnt;
    issue(t, len, ld, 1'b1, 1'b0);
    wait_blk(bb, exp_q.size() * 50 + GAP + 100, nm);
    check_block(gb, rb, bb, len, nm);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, ".gen_start"}, int'(bus.gen_start), 0);
    chk({nm, ".gen_din"}, int'(bus.gen_din), 0);
    chk({nm, ".data_rd"}, int'(bus.data_rd), 0);
    chk({nm, ".data_addr"}, int'(bus.data_addr), 0);
    chk({nm, ".busy"}, int'(bus.busy), 0);
    chk({nm, ".blk_done"}, int'(bus.blk_done), 0);
    chk({nm, ".aborted"}, int'(bus.aborted), 0);
  endtask

  initial begin
    int gb, bb;
    logic [7:0] t, len, ld;
    bus.cmd_start  = 1'b0;
    bus.cmd_abort  = 1'b0;
    bus.cmd_type   = 8'h00;
    bus.cmd_len    = 8'h00;
    bus.cmd_leader = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk); #1;

    mem[0] = 8'h10;
    mem[1] = 8'h20;
    run_block(8'h01, 8'd2, 8'd0, "blkA");
    chk("blkA.csum", int'(got_q[got_q.size() - 2]), 8'h33);

    run_block(8'hFF, 8'd0, 8'd3, "blkB");

    mem[0] = 8'hFF;
    run_block(8'h01, 8'd1, 8'd0, "blkC");
    chk("blkC.csum", int'(got_q[got_q.size() - 2]), 8'h01);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      t   = 8'($urandom);
      len = 8'($urandom_range(12, 0));
      ld  = 8'($urandom_range(2, 0));
      run_block(t, len, ld, $sformatf("rnd%0d", k));
    end

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    t = 8'($urandom);
    model(t, 8'd8, 8'd0);
    gb = got_q.size();
    bb = blk_cnt;
    issue(t, 8'd8, 8'd0, 1'b1, 1'b0);
    wait_starts(gb + 7, 400, "abt");
    bus.cmd_abort = 1'b1;
    @(negedge clk); #1;
    bus.cmd_abort = 1'b0;
    wait_blk(bb, 100, "abt");
    chk("abt.nblk", blk_cnt - bb, 1);
    chk("abt.done_lat", blk_cyc - rise_cyc, 1);
    chk("abt.aborted", int'(blk_ab), 1);
    chk("abt.busy_at_done", int'(blk_busy), 0);
    repeat (60) @(negedge clk);
    #1;
    chk("abt.nbytes", got_q.size() - gb, 7);
    for (int i = 0; i < 7; i++)
      if (gb + i < got_q.size())
        chk($sformatf("abt.byte%0d", i),
            int'(got_q[gb + i]), int'(exp_q[i]));
    chk("abt.busy_after", int'(bus.busy), 0);
    chk("abt.nblk_after", blk_cnt - bb, 1);

    mem[0] = 8'h5A;
    model(8'h42, 8'd1, 8'd0);
    gb = got_q.size();
    bb = blk_cnt;
    begin
      int rb;
      rb = rd_cnt;
      issue(8'h42, 8'd1, 8'd0, 1'b1, 1'b0);
      wait_starts(gb + 2, 200, "busy_start");
      issue(8'h99, 8'd3, 8'd2, 1'b1, 1'b0);
      wait_blk(bb, exp_q.size() * 50 + GAP + 100,
               "busy_start");
      check_block(gb, rb, bb, 8'd1, "busy_start");
    end

    gb = got_q.size();
    bb = blk_cnt;
    issue(8'h07, 8'd4, 8'd1, 1'b1, 1'b1);
    repeat (60) @(negedge clk);
    #1;
    chk("idle_abort.busy", int'(bus.busy), 0);
    chk("idle_abort.nbytes", got_q.size() - gb, 0);
    chk("idle_abort.nblk", blk_cnt - bb, 0);
    chk("idle_abort.aborted", int'(bus.aborted), 0);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    gb = got_q.size();
    issue(8'h3E, 8'd5, 8'd0, 1'b1, 1'b0);
    wait_starts(gb + 5, 400, "rst");
    repeat (10) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    gb = got_q.size();
    bb = blk_cnt;
    repeat (60) @(negedge clk);
    #1;
    chk("rst.no_start", got_q.size() - gb, 0);
    chk("rst.no_blk", blk_cnt - bb, 0);
    chk("rst.busy", int'(bus.busy), 0);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_block(8'($urandom), 8'd4, 8'd1, "post_rst");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
